// File: rtl/game_timer_bcd.sv
// N-digit BCD seconds timer with a 1 s prescaler, up/down counting,
// preload and the sticky Expired / Overflow status flags.
module game_timer_bcd #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int DIGITS        = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Enable,
  input  logic                Clear,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] Load_Val,
  input  logic                Count_Down,
  output logic [4*DIGITS-1:0] Sec_Bcd,
  output logic                Sec_Tick,
  output logic                Expired,
  output logic                Overflow
);

  localparam int              PW        = $clog2(TICKS_PER_SEC);
  localparam int              VW        = 4 * DIGITS;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [VW-1:0] sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          expired_q, expired_d;
  logic          overflow_q, overflow_d;

  logic [VW-1:0] inc_val, dec_val, load_clamped;
  logic          carry, borrow, all_nines, is_zero;
  logic          halted, run, sec_event;

  // NOTE: blocking assignments are correct here; carry must ripple
  // digit to digit within the same evaluation.
  always_comb begin
    inc_val   = sec_q;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sec_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (sec_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = sec_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    dec_val = sec_q;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (sec_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = sec_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    load_clamped = Load_Val;
    for (int i = 0; i < DIGITS; i++) begin
      if (Load_Val[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
    end
  end

  assign is_zero   = (sec_q == '0);
  assign halted    = Count_Down ? expired_q : overflow_q;
  assign run       = Enable && !halted;
  assign sec_event = run && (presc_q == PRESC_MAX);

  // NOTE: every target gets a default first so no path leaves one
  // unassigned and infers a latch.
  always_comb begin
    sec_d      = sec_q;
    presc_d    = presc_q;
    tick_d     = 1'b0;
    expired_d  = expired_q;
    overflow_d = overflow_q;
    if (Clear) begin
      sec_d      = '0;
      presc_d    = '0;
      expired_d  = 1'b0;
      overflow_d = 1'b0;
    end else if (Load) begin
      sec_d      = load_clamped;
      presc_d    = '0;
      overflow_d = 1'b0;
      expired_d  = Count_Down && (Load_Val == '0);
    end else if (sec_event) begin
      presc_d = '0;
      if (!Count_Down) begin
        if (all_nines) begin
          overflow_d = 1'b1;
        end else begin
          sec_d  = inc_val;
          tick_d = 1'b1;
        end
      end else if (is_zero) begin
        // Down-count from an already-zero value just latches expiry.
        expired_d = 1'b1;
      end else begin
        sec_d  = dec_val;
        tick_d = 1'b1;
        if (dec_val == '0) expired_d = 1'b1;
      end
    end else if (run) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sec_q      <= '0;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      expired_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      expired_q  <= expired_d;
      overflow_q <= overflow_d;
    end
  end

  assign Sec_Bcd  = sec_q;
  assign Sec_Tick = tick_q;
  assign Expired  = expired_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_game_timer_bcd.sv
// Directed bench for game_timer_bcd with TICKS_PER_SEC=10, DIGITS=2.
module tb_game_timer_bcd;

  localparam int TPS = 10;
  localparam int DG  = 2;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Enable;
  logic          Clear;
  logic          Load;
  logic [4*DG-1:0] Load_Val;
  logic          Count_Down;
  logic [4*DG-1:0] Sec_Bcd;
  logic          Sec_Tick;
  logic          Expired;
  logic          Overflow;

  int n_cmp = 0;
  int n_bad = 0;

  game_timer_bcd #(.TICKS_PER_SEC(TPS), .DIGITS(DG)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Enable     (Enable),
    .Clear      (Clear),
    .Load       (Load),
    .Load_Val   (Load_Val),
    .Count_Down (Count_Down),
    .Sec_Bcd    (Sec_Bcd),
    .Sec_Tick   (Sec_Tick),
    .Expired    (Expired),
    .Overflow   (Overflow)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] bcd2(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_value(input logic [7:0] v);
    Load_Val = v;
    Load     = 1'b1;
    step();
    Load     = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0; Enable = 1'b0; Clear = 1'b0; Load = 1'b0;
    Load_Val = '0; Count_Down = 1'b0;
    #2;
    n_cmp++;
    if ({Sec_Bcd, Sec_Tick, Expired, Overflow} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_state: got bcd=%h tick=%b exp=%b ovf=%b, want all 0",
               Sec_Bcd, Sec_Tick, Expired, Overflow);
    end
    repeat (2) step();
    Rst = 1'b1;
  endtask

  task automatic test_count_up();
    Enable = 1'b1; Count_Down = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      step();
      n_cmp++;
      if (Sec_Bcd !== bcd2(k / 10) || Sec_Tick !== (k % 10 == 0)) begin
        n_bad++;
        $display("FAIL count_up cyc %0d: got bcd=%h tick=%b, want bcd=%h tick=%b",
                 k, Sec_Bcd, Sec_Tick, bcd2(k / 10), (k % 10 == 0));
      end
    end
    n_cmp++;
    if (Expired !== 1'b0 || Overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL count_up_flags: got exp=%b ovf=%b, want 0 0", Expired, Overflow);
    end
  endtask

  task automatic test_overflow();
    load_value(8'h98);
    n_cmp++;
    if (Sec_Bcd !== 8'h98 || Sec_Tick !== 1'b0) begin
      n_bad++;
      $display("FAIL load_98: got bcd=%h tick=%b, want 98 0", Sec_Bcd, Sec_Tick);
    end
    repeat (TPS) step();
    n_cmp++;
    if (Sec_Bcd !== 8'h99 || Sec_Tick !== 1'b1 || Overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL step_to_99: got bcd=%h tick=%b ovf=%b, want 99 1 0",
               Sec_Bcd, Sec_Tick, Overflow);
    end
    for (int k = 1; k <= TPS; k++) begin
      step();
      n_cmp++;
      if (Sec_Bcd !== 8'h99 || Sec_Tick !== 1'b0 || Overflow !== (k == TPS)) begin
        n_bad++;
        $display("FAIL saturate cyc %0d: got bcd=%h tick=%b ovf=%b, want 99 0 %b",
                 k, Sec_Bcd, Sec_Tick, Overflow, (k == TPS));
      end
    end
    // Halted for 25 cycles; a frozen prescaler means a full second after release.
    repeat (25) step();
    Count_Down = 1'b1;
    for (int k = 1; k <= TPS; k++) begin
      step();
      n_cmp++;
      if (Sec_Tick !== (k == TPS) || Sec_Bcd !== ((k == TPS) ? 8'h98 : 8'h99)) begin
        n_bad++;
        $display("FAIL halt_release cyc %0d: got bcd=%h tick=%b, want %h %b",
                 k, Sec_Bcd, Sec_Tick, (k == TPS) ? 8'h98 : 8'h99, (k == TPS));
      end
    end
    n_cmp++;
    if (Overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_sticky: got ovf=%b, want 1", Overflow);
    end
  endtask

  task automatic test_countdown();
    Count_Down = 1'b1;
    load_value(8'h03);
    n_cmp++;
    if (Sec_Bcd !== 8'h03 || Expired !== 1'b0 || Overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL load_03: got bcd=%h exp=%b ovf=%b, want 03 0 0",
               Sec_Bcd, Expired, Overflow);
    end
    for (int s = 2; s >= 0; s--) begin
      repeat (TPS - 1) step();
      n_cmp++;
      if (Sec_Bcd !== bcd2(s + 1) || Sec_Tick !== 1'b0 || Expired !== 1'b0) begin
        n_bad++;
        $display("FAIL down_pre %0d: got bcd=%h tick=%b exp=%b, want %h 0 0",
                 s, Sec_Bcd, Sec_Tick, Expired, bcd2(s + 1));
      end
      step();
      n_cmp++;
      if (Sec_Bcd !== bcd2(s) || Sec_Tick !== 1'b1 || Expired !== (s == 0)) begin
        n_bad++;
        $display("FAIL down_step %0d: got bcd=%h tick=%b exp=%b, want %h 1 %b",
                 s, Sec_Bcd, Sec_Tick, Expired, bcd2(s), (s == 0));
      end
    end
    for (int k = 1; k <= 3 * TPS; k++) begin
      step();
      n_cmp++;
      if (Sec_Bcd !== 8'h00 || Sec_Tick !== 1'b0 || Expired !== 1'b1) begin
        n_bad++;
        $display("FAIL expired_hold cyc %0d: got bcd=%h tick=%b exp=%b, want 00 0 1",
                 k, Sec_Bcd, Sec_Tick, Expired);
      end
    end
    load_value(8'h00);
    n_cmp++;
    if (Sec_Bcd !== 8'h00 || Expired !== 1'b1 || Sec_Tick !== 1'b0) begin
      n_bad++;
      $display("FAIL load_zero_down: got bcd=%h exp=%b tick=%b, want 00 1 0",
               Sec_Bcd, Expired, Sec_Tick);
    end
  endtask

  task automatic test_pause();
    Count_Down = 1'b0;
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    n_cmp++;
    if (Sec_Bcd !== 8'h00 || Expired !== 1'b0 || Overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL clear: got bcd=%h exp=%b ovf=%b, want 00 0 0",
               Sec_Bcd, Expired, Overflow);
    end
    repeat (4) step();
    Enable = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_cmp++;
      if (Sec_Bcd !== 8'h00 || Sec_Tick !== 1'b0) begin
        n_bad++;
        $display("FAIL paused cyc %0d: got bcd=%h tick=%b, want 00 0", k, Sec_Bcd, Sec_Tick);
      end
    end
    Enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_cmp++;
      if (Sec_Tick !== (k == 6) || Sec_Bcd !== ((k == 6) ? 8'h01 : 8'h00)) begin
        n_bad++;
        $display("FAIL resume cyc %0d: got bcd=%h tick=%b, want %h %b",
                 k, Sec_Bcd, Sec_Tick, (k == 6) ? 8'h01 : 8'h00, (k == 6));
      end
    end
  endtask

  task automatic test_load_clear();
    Load_Val = 8'h45; Load = 1'b1; Clear = 1'b1;
    step();
    Load = 1'b0; Clear = 1'b0;
    n_cmp++;
    if (Sec_Bcd !== 8'h00) begin
      n_bad++;
      $display("FAIL clear_over_load: got bcd=%h, want 00", Sec_Bcd);
    end
    load_value(8'h4F);
    n_cmp++;
    if (Sec_Bcd !== 8'h49) begin
      n_bad++;
      $display("FAIL clamp_low: got bcd=%h, want 49", Sec_Bcd);
    end
    load_value(8'hFA);
    n_cmp++;
    if (Sec_Bcd !== 8'h99 || Overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL clamp_both: got bcd=%h ovf=%b, want 99 0", Sec_Bcd, Overflow);
    end
  endtask

  task automatic test_async_reset();
    Count_Down = 1'b1;
    load_value(8'h00);
    Count_Down = 1'b0;
    repeat (37 * TPS) step();
    n_cmp++;
    if (Sec_Bcd !== 8'h37 || Expired !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset: got bcd=%h exp=%b, want 37 1", Sec_Bcd, Expired);
    end
    repeat (4) step();
    #2;
    Rst = 1'b0;
    #1;
    n_cmp++;
    if ({Sec_Bcd, Sec_Tick, Expired, Overflow} !== 11'd0) begin
      n_bad++;
      $display("FAIL async_reset: got bcd=%h tick=%b exp=%b ovf=%b, want all 0",
               Sec_Bcd, Sec_Tick, Expired, Overflow);
    end
    repeat (2) step();
    Rst = 1'b1;
    for (int k = 1; k <= TPS; k++) begin
      step();
      n_cmp++;
      if (Sec_Tick !== (k == TPS) || Sec_Bcd !== ((k == TPS) ? 8'h01 : 8'h00)) begin
        n_bad++;
        $display("FAIL post_reset cyc %0d: got bcd=%h tick=%b, want %h %b",
                 k, Sec_Bcd, Sec_Tick, (k == TPS) ? 8'h01 : 8'h00, (k == TPS));
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_overflow();
    test_countdown();
    test_pause();
    test_load_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
